// File: rtl/uart_tx_arb.sv
// Round-robin packet arbiter feeding the uart_tx write port.
// Grants whole packets, optionally prefixed by an {id, len-1} header.
module uart_tx_arb #(
  parameter int NumReq = 4,
  parameter int IdBits = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   c_enable,
  input  logic                   c_hdr_en,
  input  logic [NumReq-1:0]      i_req,
  input  logic [NumReq-1:0][3:0] i_len_m1,
  input  logic [NumReq-1:0][7:0] i_data,
  output logic [NumReq-1:0]      o_ack,
  output logic [NumReq-1:0]      o_grant,
  output logic                   o_busy,
  input  logic                   i_fifo_full,
  output logic                   o_fifo_write,
  output logic [7:0]             o_fifo_wdata
);

  localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int SumW = IdxW + 1;
  localparam logic [NumReq-1:0] One = 1;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    PAYLOAD
  } state_t;

  state_t            state;
  logic [IdxW-1:0]   ptr;
  logic [IdxW-1:0]   gidx;
  logic [3:0]        cnt;
  logic [3:0]        len_q;
  logic [NumReq-1:0] rot;
  logic [IdxW-1:0]   pick;
  logic              pick_ok;
  logic [SumW-1:0]   sum;

  // Rotate so bit 0 is the pointer; lowest set bit wins.
  always_comb begin
    rot = NumReq'({i_req, i_req} >> ptr);
    pick_ok = 1'b0;
    pick = '0;
    sum = '0;
    for (int k = NumReq - 1; k >= 0; k--) begin
      if (rot[k]) begin
        pick_ok = 1'b1;
        sum = SumW'(ptr) + SumW'(k);
        if (sum >= SumW'(NumReq)) begin
          sum = sum - SumW'(NumReq);
        end
        pick = sum[IdxW-1:0];
      end
    end
  end

  assign o_busy       = (state != IDLE);
  assign o_fifo_write = o_busy && !i_fifo_full;

  always_comb begin
    o_fifo_wdata = '0;
    o_ack = '0;
    unique case (state)
      HEADER:  o_fifo_wdata = {IdBits'(gidx), len_q};
      PAYLOAD: begin
        o_fifo_wdata = i_data[gidx];
        if (!i_fifo_full) begin
          o_ack = o_grant;
        end
      end
      default: o_fifo_wdata = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      o_grant <= '0;
      ptr     <= '0;
      gidx    <= '0;
      cnt     <= '0;
      len_q   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (c_enable && pick_ok) begin
            o_grant <= One << pick;
            gidx    <= pick;
            len_q   <= i_len_m1[pick];
            cnt     <= '0;
            ptr     <= (pick == IdxW'(NumReq - 1)) ? '0 : pick + 1'b1;
            state   <= c_hdr_en ? HEADER : PAYLOAD;
          end
        end
        HEADER: begin
          if (!i_fifo_full) begin
            state <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (!i_fifo_full) begin
            cnt <= cnt + 1'b1;
            if (cnt == len_q) begin
              state   <= IDLE;
              o_grant <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
